ahb_sif_mem: RTL and testbench
==============================

Name: ahb_sif_mem

Overview:
- Behavioural AHB-Lite slave memory model used as the instruction, load/store and debug-system-bus target in core-level simulation.
- Byte-addressed memory, 64-bit data bus, zero wait states, never returns an error.
- Decodes a write-only mailbox address.
- Flags each mailbox write so the bench can print console characters and detect end-of-test (data byte 0xFF).

Parameters:
MEM_AW, 20, byte address width of storage; depth is 2^MEM_AW bytes, indexed by HADDR[MEM_AW-1:0] (upper bits ignored, aliasing).
MAILBOX_ADDR, 32'hD058_0000, write address that raises mailbox_write.

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  slave select
HADDR  in  32  byte address
HTRANS  in  2  transfer type; bit1=1 (NONSEQ/SEQ) means active
HWRITE  in  1  1=write, 0=read
HSIZE  in  3  0=byte, 1=half, 2=word, 3=dword
HBURST  in  3  accepted, ignored
HPROT  in  4  accepted, ignored
HREADY  in  1  bus-level ready; address phase accepted only when 1
HWDATA  in  64  write data (data phase)
HRDATA  out  64  read data
HREADYOUT  out  1  slave ready
HRESP  out  1  response, constant 0 (OKAY)
mailbox_write  out  1  one-cycle pulse per completed mailbox write
WriteData  out  64  HWDATA of most recent completed write, held

Behaviour:
- Storage:
  - Unpacked byte array named mem, MEM_AW-bit index, so a bench can $readmemh into it hierarchically.
  - Not cleared by reset; initial content is whatever was loaded, X otherwise.
- Address phase accept condition: HSEL & HREADY & HTRANS[1] at a rising HCLK edge.
  - On accept, register HADDR, HWRITE, HSIZE and a data-phase-valid flag.
  - Otherwise clear the valid flag.
- Reset (asynchronous, HRESETn=0):
  - Valid flag=0, mailbox_write=0, WriteData=0, HREADYOUT=1, HRESP=0, HRDATA=0.
  - Reset mid-transfer drops the pending data phase; no memory write occurs.
- HREADYOUT is 1 at all times (zero wait states), so every data phase completes in the cycle after its address phase.
- HRESP is always 0.
- Write:
  - At the rising edge ending a write data phase, for each byte k in 0..(2^HSIZE - 1), write mem[A+k] = HWDATA[8*(A[2:0]+k) +: 8], where A is the registered address.
  - Lanes beyond byte 7 are dropped: misaligned accesses never cross the doubleword.
  - On the same edge, WriteData <= HWDATA.
  - If A == MAILBOX_ADDR, also set mailbox_write=1 for exactly one cycle. The mailbox write is also stored to mem.
  - mailbox_write returns to 0 on the next edge. WriteData holds, so it is stable at the falling edge of mailbox_write.
  - Back-to-back mailbox writes produce mailbox_write held high across both cycles, with WriteData updated each cycle.
- Read:
  - HRDATA is combinational: {mem[D+7] .. mem[D]}, with D = registered address with bits[2:0] cleared.
  - Valid throughout the read data phase; HSIZE does not mask lanes.
  - Outside a read data phase HRDATA shows the last registered address's doubleword.
- Write-then-read to the same address in consecutive transfers returns the new data (write commits at the edge where the read address is sampled).
- HSEL=0, HTRANS=IDLE/BUSY or HREADY=0: no state change (an instance with HREADY tied 0 never accepts transfers).

Test Plan:
- Reset: hold HRESETn=0 → HREADYOUT=1, HRESP=0, mailbox_write=0, WriteData=0. Release with HTRANS=IDLE → no change.
- Dword write/read: write HADDR=0x80000008, HSIZE=3, HWDATA=0x1122334455667788; then read the same address → HRDATA=0x1122334455667788 in the data phase, one cycle after the address phase.
- Sub-word write: after the above, write a byte at 0x8000000B with HWDATA=0x00000000AA000000 and a half at 0x8000000E with HWDATA=0xBEEF000000000000 → read returns 0xBEEF3344AA667788.
- Mailbox: write 0x41 then 0xFF to 0xD0580000 with one idle cycle between → two single-cycle mailbox_write pulses. WriteData[7:0]=0x41 then 0xFF at each pulse's falling edge. mem[0x80000] updated.
- Preload: $readmemh into mem with 0x13 at byte 0x100, then read 0x100 → HRDATA[7:0]=0x13.
- Gating: HSEL=1, HTRANS=2, HREADY=0, write 0xDEAD to 0x10 → no memory change, and a subsequent read of 0x10 returns the prior contents.

Source files
------------

// File: rtl/ahb_sif_mem.sv
// Behavioural AHB-Lite slave memory: byte-addressed, 64-bit data, zero wait states, OKAY only.
// Writes to MAILBOX_ADDR pulse mailbox_write so a bench can print characters or detect 0xFF.
module ahb_sif_mem #(
    parameter int unsigned MEM_AW       = 20,
    parameter logic [31:0] MAILBOX_ADDR = 32'hD058_0000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HREADY,
    input  logic [63:0] HWDATA,
    output logic [63:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic        mailbox_write,
    output logic [63:0] WriteData
);

    // Not reset: contents come from preload or bus writes only.
    logic [7:0] mem [0:2**MEM_AW-1];

    logic        valid_q, valid_d;
    logic [31:0] haddr_q, haddr_d;
    logic        hwrite_q, hwrite_d;
    logic [2:0]  hsize_q, hsize_d;
    logic        mailbox_q, mailbox_d;
    logic [63:0] wdata_q, wdata_d;

    logic        accept;
    logic        wr_commit;
    logic [7:0]  be;
    logic [63:0] rdata;
    int unsigned off;
    int unsigned nbytes;

    logic unused_ok;
    assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

    assign accept    = HSEL & HREADY & HTRANS[1];
    assign wr_commit = valid_q & hwrite_q;
    assign off       = 32'(haddr_q[2:0]);
    assign nbytes    = 32'd1 << hsize_q;

    always_comb begin
        valid_d   = accept;
        haddr_d   = haddr_q;
        hwrite_d  = hwrite_q;
        hsize_d   = hsize_q;
        wdata_d   = wdata_q;
        mailbox_d = wr_commit && (haddr_q == MAILBOX_ADDR);
        if (accept) begin
            haddr_d  = HADDR;
            hwrite_d = HWRITE;
            hsize_d  = HSIZE;
        end
        if (wr_commit) begin
            wdata_d = HWDATA;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            valid_q   <= 1'b0;
            haddr_q   <= '0;
            hwrite_q  <= 1'b0;
            hsize_q   <= '0;
            mailbox_q <= 1'b0;
            wdata_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            haddr_q   <= haddr_d;
            hwrite_q  <= hwrite_d;
            hsize_q   <= hsize_d;
            mailbox_q <= mailbox_d;
            wdata_q   <= wdata_d;
        end
    end

    // Lanes past byte 7 are clipped so a misaligned access never spills into the next dword.
    always_comb begin
        be = '0;
        for (int unsigned b = 0; b < 8; b++) begin
            if (b >= off && b < off + nbytes) begin
                be[b] = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (wr_commit) begin
            for (int b = 0; b < 8; b++) begin
                if (be[b]) begin
                    mem[{haddr_q[MEM_AW-1:3], 3'(b)}] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int b = 0; b < 8; b++) begin
            rdata[8*b +: 8] = mem[{haddr_q[MEM_AW-1:3], 3'(b)}];
        end
    end

    assign HRDATA        = HRESETn ? rdata : '0;
    assign HREADYOUT     = 1'b1;
    assign HRESP         = 1'b0;
    assign mailbox_write = mailbox_q;
    assign WriteData     = wdata_q;

endmodule

// File: tb/tb_ahb_sif_mem.sv
// Directed bench for ahb_sif_mem: vector table of single transfers plus hand-written
// sequences for reset, mailbox pulses and HREADY gating.
module tb_ahb_sif_mem;

    localparam logic [31:0] MBX = 32'hD058_0000;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HREADY;
    logic [63:0] HWDATA;
    logic [63:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic        mailbox_write;
    logic [63:0] WriteData;

    int tests_run = 0;
    int tests_failed = 0;

    ahb_sif_mem dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .HSEL         (HSEL),
        .HADDR        (HADDR),
        .HTRANS       (HTRANS),
        .HWRITE       (HWRITE),
        .HSIZE        (HSIZE),
        .HBURST       (HBURST),
        .HPROT        (HPROT),
        .HREADY       (HREADY),
        .HWDATA       (HWDATA),
        .HRDATA       (HRDATA),
        .HREADYOUT    (HREADYOUT),
        .HRESP        (HRESP),
        .mailbox_write(mailbox_write),
        .WriteData    (WriteData)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [63:0] wdata;
        logic [63:0] exp;
        logic [63:0] mask;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: act=%h req=%h", name, act, req);
        end
    endtask

    // Address phase at one negedge, data phase at the next; read data sampled mid data phase.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [63:0] wdata, output logic [63:0] rdata);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HREADY = 1'b1;
        HWRITE = wr; HADDR = addr; HSIZE = size;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
        rdata = HRDATA;
    endtask

    task automatic set_vec(input int i, input logic wr, input logic [31:0] addr,
                           input logic [2:0] size, input logic [63:0] wdata,
                           input logic [63:0] exp, input logic [63:0] mask);
        vecs[i].wr = wr; vecs[i].addr = addr; vecs[i].size = size;
        vecs[i].wdata = wdata; vecs[i].exp = exp; vecs[i].mask = mask;
    endtask

    logic [63:0] rd;
    localparam logic [63:0] ALL = '1;

    initial begin
        set_vec(0,  1, 32'h8000_0008, 3, 64'h1122_3344_5566_7788, 0, 0);
        set_vec(1,  0, 32'h8000_0008, 3, 0, 64'h1122_3344_5566_7788, ALL);
        set_vec(2,  1, 32'h8000_000B, 0, 64'h0000_0000_AA00_0000, 0, 0);
        set_vec(3,  1, 32'h8000_000E, 1, 64'hBEEF_0000_0000_0000, 0, 0);
        set_vec(4,  0, 32'h8000_0008, 3, 0, 64'hBEEF_3344_AA66_7788, ALL);
        set_vec(5,  0, 32'h8000_0009, 0, 0, 64'hBEEF_3344_AA66_7788, ALL);
        set_vec(6,  1, 32'h8000_0010, 3, 64'h0, 0, 0);
        set_vec(7,  1, 32'h8000_0014, 2, 64'hDEAD_BEEF_0000_0000, 0, 0);
        set_vec(8,  1, 32'h8000_0018, 3, 64'h5555_5555_5555_5555, 0, 0);
        set_vec(9,  1, 32'h8000_0016, 2, 64'h1234_5678_0000_0000, 0, 0);
        set_vec(10, 0, 32'h8000_0010, 3, 0, 64'h1234_BEEF_0000_0000, ALL);
        set_vec(11, 0, 32'h8000_0018, 3, 0, 64'h5555_5555_5555_5555, ALL);
        set_vec(12, 0, 32'h0000_0010, 3, 0, 64'h1234_BEEF_0000_0000, ALL);
        set_vec(13, 1, 32'h0000_0100, 0, 64'h13, 0, 0);
        set_vec(14, 0, 32'h0000_0100, 3, 0, 64'h13, 64'hFF);
        set_vec(15, 1, 32'h8000_0020, 3, 64'h0123_4567_89AB_CDEF, 0, 0);
        set_vec(16, 0, 32'h8000_0020, 3, 0, 64'h0123_4567_89AB_CDEF, ALL);

        HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
        HSIZE = '0; HBURST = '0; HPROT = '0; HREADY = 1'b1; HWDATA = '0;

        repeat (3) @(negedge HCLK);
        check("rst_hreadyout", 64'(HREADYOUT), 64'h1);
        check("rst_hresp", 64'(HRESP), 64'h0);
        check("rst_mailbox", 64'(mailbox_write), 64'h0);
        check("rst_writedata", WriteData, 64'h0);
        check("rst_hrdata", HRDATA, 64'h0);
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);
        check("idle_mailbox", 64'(mailbox_write), 64'h0);
        check("idle_writedata", WriteData, 64'h0);

        for (int i = 0; i < 17; i++) begin
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, rd);
            if (vecs[i].wr) begin
                @(negedge HCLK);
                check($sformatf("v%0d_writedata", i), WriteData, vecs[i].wdata);
                check($sformatf("v%0d_no_mailbox", i), 64'(mailbox_write), 64'h0);
            end else begin
                check($sformatf("v%0d_hrdata", i), rd & vecs[i].mask, vecs[i].exp);
                check($sformatf("v%0d_hreadyout", i), 64'(HREADYOUT), 64'h1);
            end
        end

        // Two mailbox writes separated by an idle cycle
        xfer(1, MBX, 0, 64'h41, rd);
        @(negedge HCLK);
        check("mbx1_pulse", 64'(mailbox_write), 64'h1);
        check("mbx1_data", 64'(WriteData[7:0]), 64'h41);
        check("mbx1_mem", 64'(dut.mem[20'h80000]), 64'h41);
        @(negedge HCLK);
        check("mbx1_end", 64'(mailbox_write), 64'h0);
        check("mbx1_hold", 64'(WriteData[7:0]), 64'h41);
        xfer(1, MBX, 0, 64'hFF, rd);
        @(negedge HCLK);
        check("mbx2_pulse", 64'(mailbox_write), 64'h1);
        check("mbx2_data", 64'(WriteData[7:0]), 64'hFF);
        @(negedge HCLK);
        check("mbx2_end", 64'(mailbox_write), 64'h0);
        check("mbx2_hold", 64'(WriteData[7:0]), 64'hFF);
        check("mbx2_mem", 64'(dut.mem[20'h80000]), 64'hFF);

        // Back-to-back mailbox writes keep the pulse high for two cycles
        @(negedge HCLK);
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = MBX; HSIZE = 0;
        @(negedge HCLK);
        HWDATA = 64'h11;
        @(negedge HCLK);
        check("b2b_pulse1", 64'(mailbox_write), 64'h1);
        check("b2b_data1", WriteData, 64'h11);
        HSEL = 0; HTRANS = 2'b00; HWDATA = 64'h22;
        @(negedge HCLK);
        check("b2b_pulse2", 64'(mailbox_write), 64'h1);
        check("b2b_data2", WriteData, 64'h22);
        @(negedge HCLK);
        check("b2b_end", 64'(mailbox_write), 64'h0);

        // Reset during a write data phase drops the write
        @(negedge HCLK);
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h8000_0020; HSIZE = 3;
        @(negedge HCLK);
        HSEL = 0; HTRANS = 2'b00; HWDATA = '1; HRESETn = 1'b0;
        #1;
        check("mid_rst_writedata", WriteData, 64'h0);
        check("mid_rst_hrdata", HRDATA, 64'h0);
        check("mid_rst_hreadyout", 64'(HREADYOUT), 64'h1);
        @(negedge HCLK);
        HRESETn = 1'b1;
        xfer(0, 32'h8000_0020, 3, 0, rd);
        check("mid_rst_mem", rd, 64'h0123_4567_89AB_CDEF);

        // HREADY low blocks the address phase
        @(negedge HCLK);
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h10; HSIZE = 1; HREADY = 0;
        @(negedge HCLK);
        HSEL = 0; HTRANS = 2'b00; HREADY = 1; HWDATA = 64'hDEAD;
        @(negedge HCLK);
        check("gate_writedata", WriteData, 64'h0);
        xfer(0, 32'h10, 3, 0, rd);
        check("gate_mem", rd, 64'h1234_BEEF_0000_0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
